// File: rtl/axi4_wr_arbiter_sched.sv
// Write-channel scheduler: round-robin AW arbitration, winner locked for its whole
// AW/W/B transaction, one write outstanding, with burst-length and BID checks.
module axi4_wr_arbiter_sched #(
   parameter int NUM    = 5,
   parameter int IDSIZE = 1,
   parameter int LSIZE  = 8,
   parameter int IDW    = (NUM > 1) ? $clog2(NUM) : 1
) (
   input  logic                    axi_aclk,
   input  logic                    axi_areset,
   input  logic [NUM-1:0]          s_awvalid,
   input  logic [NUM*IDSIZE-1:0]   s_awid,
   input  logic [NUM*LSIZE-1:0]    s_awlen,
   input  logic                    m_awready,
   input  logic                    m_wvalid,
   input  logic                    m_wready,
   input  logic                    m_wlast,
   input  logic                    m_bvalid,
   input  logic                    m_bready,
   input  logic [IDSIZE+IDW-1:0]   m_bid,
   output logic [NUM-1:0]          grant,
   output logic [IDW-1:0]          grant_idx,
   output logic [IDSIZE+IDW-1:0]   m_awid,
   output logic                    aw_en,
   output logic                    w_en,
   output logic                    b_en,
   output logic                    busy,
   output logic [LSIZE:0]          beat_cnt,
   output logic                    err_len,
   output logic                    err_bid,
   output logic [1:0]              dbg_state
);

   // Every channel transfer (AW, W beat, B) completes on a rising edge where valid and ready are both high.
   typedef enum logic [1:0] {IDLE = 2'd0, AW = 2'd1, W = 2'd2, B = 2'd3} state_t;

   state_t             state_q;
   logic [NUM-1:0]     grant_q;
   logic [IDW-1:0]     grant_idx_q;
   logic [IDW-1:0]     last_q;
   logic [LSIZE-1:0]   len_q;
   logic [LSIZE:0]     beat_cnt_q;
   logic               len_err_seen_q;
   logic               aw_en_q, w_en_q, b_en_q, busy_q;
   logic               err_len_q, err_bid_q;

   logic [IDSIZE-1:0]  awid_arr  [NUM];
   logic [LSIZE-1:0]   awlen_arr [NUM];
   logic [IDW-1:0]     win_idx_d;
   logic               win_vld_d;
   logic [NUM-1:0]     grant_d;
   logic [IDW-1:0]     cand_idx;
   int                 cand;
   logic               unused_bid_lo;

   always_comb begin
      for (int i = 0; i < NUM; i++) begin
         awid_arr[i]  = s_awid[i*IDSIZE +: IDSIZE];
         awlen_arr[i] = s_awlen[i*LSIZE +: LSIZE];
      end
   end

   // First requester at or after last+1, scanning upward with wrap.
   always_comb begin
      win_idx_d = '0;
      win_vld_d = 1'b0;
      cand      = 0;
      cand_idx  = '0;
      for (int k = 1; k <= NUM; k++) begin
         cand     = (int'(last_q) + k) % NUM;
         cand_idx = IDW'(cand);
         if (!win_vld_d && s_awvalid[cand_idx]) begin
            win_vld_d = 1'b1;
            win_idx_d = cand_idx;
         end
      end
      grant_d            = '0;
      grant_d[win_idx_d] = 1'b1;
   end

   always_ff @(posedge axi_aclk) begin
      if (axi_areset) begin
         state_q        <= IDLE;
         grant_q        <= '0;
         grant_idx_q    <= '0;
         last_q         <= IDW'(NUM - 1);
         len_q          <= '0;
         beat_cnt_q     <= '0;
         len_err_seen_q <= 1'b0;
         aw_en_q        <= 1'b0;
         w_en_q         <= 1'b0;
         b_en_q         <= 1'b0;
         busy_q         <= 1'b0;
         err_len_q      <= 1'b0;
         err_bid_q      <= 1'b0;
      end else begin
         err_len_q <= 1'b0;
         err_bid_q <= 1'b0;
         case (state_q)
            IDLE: if (win_vld_d) begin
               state_q     <= AW;
               grant_q     <= grant_d;
               grant_idx_q <= win_idx_d;
               aw_en_q     <= 1'b1;
               busy_q      <= 1'b1;
            end
            AW: if (s_awvalid[grant_idx_q] && m_awready) begin
               state_q        <= W;
               len_q          <= awlen_arr[grant_idx_q];
               beat_cnt_q     <= '0;
               len_err_seen_q <= 1'b0;
               aw_en_q        <= 1'b0;
               w_en_q         <= 1'b1;
            end
            W: if (m_wvalid && m_wready) begin
               if (beat_cnt_q != '1) beat_cnt_q <= beat_cnt_q + 1'b1;
               // A burst reports its length violation once, whichever beat reveals it first.
               if (m_wlast) begin
                  state_q <= B;
                  w_en_q  <= 1'b0;
                  b_en_q  <= 1'b1;
                  if (!len_err_seen_q && beat_cnt_q != {1'b0, len_q}) err_len_q <= 1'b1;
               end else if (!len_err_seen_q && beat_cnt_q == {1'b0, len_q}) begin
                  err_len_q      <= 1'b1;
                  len_err_seen_q <= 1'b1;
               end
            end
            B: if (m_bvalid && m_bready) begin
               state_q <= IDLE;
               last_q  <= grant_idx_q;
               b_en_q  <= 1'b0;
               busy_q  <= 1'b0;
               if (m_bid[IDSIZE+IDW-1 -: IDW] != grant_idx_q) err_bid_q <= 1'b1;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign unused_bid_lo = ^m_bid[IDSIZE-1:0];

   assign grant     = (NUM == 1) ? '1 : grant_q;
   assign grant_idx = grant_idx_q;
   assign m_awid    = {grant_idx_q, awid_arr[grant_idx_q]};
   assign aw_en     = aw_en_q;
   assign w_en      = w_en_q;
   assign b_en      = b_en_q;
   assign busy      = busy_q;
   assign beat_cnt  = beat_cnt_q;
   assign err_len   = err_len_q;
   assign err_bid   = err_bid_q;
   assign dbg_state = state_q;

endmodule
